// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: shares the register-file write port between MEM/WB and a
// long-latency unit, forcing a one-cycle pipeline stall when the LU has waited too long.
module wb_port_arbiter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            lu_issue_i,
  input  logic [4:0]      lu_issue_rd_i,
  input  logic            lu_valid_i,
  input  logic [4:0]      lu_rd_i,
  input  logic [XLEN-1:0] lu_data_i,
  output logic            lu_ready_o,
  output logic            stall_o,
  output logic            rf_we_o,
  output logic [4:0]      rf_rd_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic [31:0]     pend_o
);

  localparam int unsigned CntW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_WAIT - 1);

  typedef enum logic {StPipe, StForce} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]     pend_q, pend_d;

  logic            wb_req;
  logic            sel_valid;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            lu_ready;
  logic            stall;
  logic            lu_hs;
  logic            blocked;

  assign wb_req = wb_we_i && (wb_rd_i != 5'd0);

  // Source selection; the pipeline wins unless a forced LU slot is in progress.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = 5'd0;
    sel_data  = '0;
    lu_ready  = 1'b0;
    stall     = 1'b0;
    unique case (state_q)
      StPipe: begin
        if (wb_req) begin
          sel_valid = 1'b1;
          sel_rd    = wb_rd_i;
          sel_data  = wb_data_i;
        end else begin
          lu_ready = lu_valid_i;
          if (lu_valid_i) begin
            sel_valid = 1'b1;
            sel_rd    = lu_rd_i;
            sel_data  = lu_data_i;
          end
        end
      end
      StForce: begin
        stall     = 1'b1;
        lu_ready  = 1'b1;
        sel_valid = lu_valid_i;
        sel_rd    = lu_rd_i;
        sel_data  = lu_data_i;
      end
      default: ;
    endcase
    if (reset) begin
      sel_valid = 1'b0;
      sel_rd    = 5'd0;
      sel_data  = '0;
      lu_ready  = 1'b0;
      stall     = 1'b0;
    end
  end

  always_comb begin
    rf_we_o    = sel_valid && (sel_rd != 5'd0);
    rf_rd_o    = rf_we_o ? sel_rd : 5'd0;
    rf_wdata_o = rf_we_o ? sel_data : '0;
    lu_ready_o = lu_ready;
    stall_o    = stall;
    pend_o     = pend_q;
  end

  assign lu_hs   = lu_valid_i && lu_ready;
  assign blocked = (state_q == StPipe) && lu_valid_i && !lu_ready;

  // Starvation counter: MAX_WAIT consecutive blocked cycles buy the LU one forced slot.
  always_comb begin
    state_d    = StPipe;
    wait_cnt_d = '0;
    if (blocked) begin
      wait_cnt_d = wait_cnt_q + CntW'(1);
      if (wait_cnt_q == CntLast) begin
        state_d = StForce;
      end
    end
  end

  // Issue set overrides a same-cycle retire clear of the same register.
  always_comb begin
    pend_d = pend_q;
    if (lu_hs && (lu_rd_i != 5'd0)) begin
      pend_d[lu_rd_i] = 1'b0;
    end
    if (lu_issue_i && (lu_issue_rd_i != 5'd0)) begin
      pend_d[lu_issue_rd_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StPipe;
      wait_cnt_q <= '0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      pend_q     <= pend_d;
    end
  end

endmodule
